// File: rtl/sc_rr_crossbar_mem_slave_pkg.sv
// ----------------------------------------------------------------------------
// sc_rr_crossbar_mem_slave_pkg
// Shared definitions for the crossbar reference memory slave: bus widths,
// command encodings, FSM state encodings, the captured-request record and
// the address window decode helper.
// ----------------------------------------------------------------------------
package sc_rr_crossbar_mem_slave_pkg;

    localparam int SC_ADDR_W = 32;
    localparam int SC_DATA_W = 32;

    localparam logic SC_CMD_READ  = 1'b0;
    localparam logic SC_CMD_WRITE = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    // Request as captured in IDLE; everything after IDLE works from this.
    typedef struct packed {
        logic                 cmd;
        logic                 hit;
        logic [SC_ADDR_W-1:0] addr;
        logic [SC_DATA_W-1:0] wdata;
    } sc_req_t;

    // Window is 4*2**abits bytes, aligned to its own size.
    function automatic logic sc_addr_hit(input logic [SC_ADDR_W-1:0] addr,
                                         input logic [SC_ADDR_W-1:0] base,
                                         input int unsigned          abits);
        logic [SC_ADDR_W-1:0] window;
        window = 32'd4 << abits;
        return (addr & ~(window - 32'd1)) == base;
    endfunction

endpackage

// File: rtl/sc_rr_crossbar_mem_slave_ram.sv
// ----------------------------------------------------------------------------
// sc_rr_crossbar_mem_slave_ram
// Single-port synchronous RAM, 1-cycle read latency, write enable. Kept
// behaviourally plain so it can be swapped for a vendor macro.
//   i_clk    : clock
//   i_en     : access enable
//   i_we     : 1 = write, 0 = read (when i_en)
//   i_addr   : word index
//   i_wdata  : write data
//   o_rdata  : read data, registered; holds its value on writes/idle
// Contents are not reset.
// ----------------------------------------------------------------------------
module sc_rr_crossbar_mem_slave_ram #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_en,
    input  logic                 i_we,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic [DATA_W-1:0]    o_rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_BITS];

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            if (i_we) begin
                mem[i_addr] <= i_wdata;
            end else begin
                o_rdata <= mem[i_addr];
            end
        end
    end

endmodule

// File: rtl/sc_rr_crossbar_mem_slave.sv
// ----------------------------------------------------------------------------
// sc_rr_crossbar_mem_slave
// Reference memory slave behind one crossbar slave port. Accepts a req/ack
// request in IDLE, waits WAIT_CYCLES cycles, then performs it against an
// internal word-addressed RAM and pulses o_ack for one cycle.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_req          : request, held by the master until o_ack
//   i_addr         : byte address (bits [1:0] ignored)
//   i_cmd          : 1 = write, 0 = read
//   i_wdata        : write data
//   o_ack          : one-cycle completion pulse
//   o_rdata        : read data, nonzero only in the o_ack cycle of a read hit
//   o_dbg_state    : current FSM state (IDLE/WAIT/ACK encodings)
//
// Handshake: i_req is sampled only in IDLE, and only a clean 1 counts as a
// request (a floating shared bus reads as no request). Once accepted the
// inputs are ignored until the ack; the captured copy is used throughout.
// Timing: request accepted at edge N -> o_ack high in the cycle after edge
// N+WAIT_CYCLES; one transaction every 2+WAIT_CYCLES cycles back-to-back.
// ----------------------------------------------------------------------------
module sc_rr_crossbar_mem_slave
    import sc_rr_crossbar_mem_slave_pkg::*;
#(
    parameter int          ADDR_BITS   = 8,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    input  logic        i_cmd,
    input  logic [31:0] i_wdata,
    output logic        o_ack,
    output logic [31:0] o_rdata,
    output logic [1:0]  o_dbg_state
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    sc_req_t         cap_q, cap_d;
    logic            enter_ack;
    logic            ram_en;
    logic            ram_we;
    logic [SC_DATA_W-1:0] ram_rdata;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req == 1'b1) begin
                    cap_d.cmd   = i_cmd;
                    cap_d.hit   = sc_addr_hit(i_addr, BASE_ADDR, ADDR_BITS);
                    cap_d.addr  = i_addr;
                    cap_d.wdata = i_wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        cnt_d   = WAIT_LOAD;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            cap_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cap_q   <= cap_d;
        end
    end

    // The RAM is accessed on the edge that enters ACK. cap_d is used rather
    // than cap_q so that WAIT_CYCLES=0 (capture and ACK entry on the same
    // edge) works; in WAIT cap_d equals cap_q. A reset before this edge
    // means the access never happens, so a pending write is simply dropped.
    assign enter_ack = (state_d == ST_ACK) && (state_q != ST_ACK);
    assign ram_en    = enter_ack && cap_d.hit;
    assign ram_we    = (cap_d.cmd == SC_CMD_WRITE);

    sc_rr_crossbar_mem_slave_ram #(
        .ADDR_BITS (ADDR_BITS),
        .DATA_W    (SC_DATA_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_en    (ram_en),
        .i_we    (ram_we),
        .i_addr  (cap_d.addr[ADDR_BITS+1:2]),
        .i_wdata (cap_d.wdata),
        .o_rdata (ram_rdata)
    );

    // RAM output register is only meaningful in the ACK cycle of a read hit;
    // everywhere else (miss, write, idle) the bus sees zero.
    assign o_ack       = (state_q == ST_ACK);
    assign o_rdata     = (o_ack && cap_q.hit && (cap_q.cmd == SC_CMD_READ)) ? ram_rdata : '0;
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_sc_rr_crossbar_mem_slave.sv
module tb_sc_rr_crossbar_mem_slave;
  import sc_rr_crossbar_mem_slave_pkg::*;

  // index 0: WAIT_CYCLES=2, index 1: WAIT_CYCLES=0
  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [1:0]  cmd;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic [1:0]  ack;
  logic [31:0] rdata [2];
  logic [1:0]  st [2];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sc_rr_crossbar_mem_slave #(.ADDR_BITS(8), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u_dut_w2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[0]), .i_addr(addr[0]), .i_cmd(cmd[0]),
    .i_wdata(wdata[0]), .o_ack(ack[0]), .o_rdata(rdata[0]), .o_dbg_state(st[0])
  );

  sc_rr_crossbar_mem_slave #(.ADDR_BITS(8), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u_dut_w0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req[1]), .i_addr(addr[1]), .i_cmd(cmd[1]),
    .i_wdata(wdata[1]), .o_ack(ack[1]), .o_rdata(rdata[1]), .o_dbg_state(st[1])
  );

  typedef struct {
    int          s;
    logic        c;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp;
    bit          chk;
    bit          glitch;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs [NV];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // driver: one full transaction, checks ack timing and read data
  task automatic txn(input int s, input logic c, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] exp, input bit chk, input bit glitch, input string nm);
    int          wc;
    bit          lat_ok;
    logic [31:0] seen;
    wc     = (s == 0) ? 2 : 0;
    lat_ok = 1'b1;
    seen   = '0;
    @(negedge clk);
    req[s] = 1'b1; cmd[s] = c; addr[s] = a; wdata[s] = d;
    for (int i = 0; i <= wc; i++) begin
      @(posedge clk); #1;
      if (glitch) begin
        addr[s]  = a ^ 32'h4;
        wdata[s] = ~d;
      end
      if (i < wc) begin
        if (ack[s] !== 1'b0 || rdata[s] !== 32'h0) lat_ok = 1'b0;
      end else begin
        if (ack[s] !== 1'b1) lat_ok = 1'b0;
        seen = rdata[s];
      end
    end
    check({nm, " ack timing"}, {31'b0, lat_ok}, 32'd1);
    if (chk) check({nm, " rdata"}, seen, exp);
    @(posedge clk); #1;
    check({nm, " post-ack ack/rdata"}, {ack[s], rdata[s][30:0]} | {31'b0, |rdata[s]}, 32'h0);
    req[s] = 1'b0;
  endtask

  initial begin
    bit          found;
    int          t1, t2;

    vecs[0]  = '{0, SC_CMD_WRITE, 32'h10,  32'hCAFE_F00D, 32'h0,          0, 0};
    vecs[1]  = '{0, SC_CMD_READ,  32'h10,  32'h0,         32'hCAFE_F00D,  1, 0};
    vecs[2]  = '{0, SC_CMD_WRITE, 32'h14,  32'h0123_4567, 32'h0,          0, 0};
    vecs[3]  = '{0, SC_CMD_WRITE, 32'h3FC, 32'hFFFF_0000, 32'h0,          0, 0};
    vecs[4]  = '{0, SC_CMD_READ,  32'h14,  32'h0,         32'h0123_4567,  1, 0};
    vecs[5]  = '{0, SC_CMD_READ,  32'h3FC, 32'h0,         32'hFFFF_0000,  1, 0};
    vecs[6]  = '{0, SC_CMD_WRITE, 32'h410, 32'hBAD0_BAD0, 32'h0,          0, 0};
    vecs[7]  = '{0, SC_CMD_READ,  32'h10,  32'h0,         32'hCAFE_F00D,  1, 0};
    vecs[8]  = '{0, SC_CMD_READ,  32'h410, 32'h0,         32'h0,          1, 0};
    vecs[9]  = '{0, SC_CMD_READ,  32'h13,  32'h0,         32'hCAFE_F00D,  1, 0};
    vecs[10] = '{1, SC_CMD_WRITE, 32'h3FC, 32'h5A5A_5A5A, 32'h0,          0, 0};
    vecs[11] = '{1, SC_CMD_READ,  32'h3FC, 32'h0,         32'h5A5A_5A5A,  1, 0};
    vecs[12] = '{1, SC_CMD_WRITE, 32'h0,   32'h00C0_FFEE, 32'h0,          0, 0};
    vecs[13] = '{1, SC_CMD_WRITE, 32'h400, 32'hDEAD_BEEF, 32'h0,          0, 0};
    vecs[14] = '{1, SC_CMD_READ,  32'h400, 32'h0,         32'h0,          1, 0};
    vecs[15] = '{1, SC_CMD_READ,  32'h0,   32'h0,         32'h00C0_FFEE,  1, 0};
    vecs[16] = '{0, SC_CMD_WRITE, 32'h34,  32'h5555_5555, 32'h0,          0, 0};
    vecs[17] = '{0, SC_CMD_WRITE, 32'h30,  32'h1111_2222, 32'h0,          0, 1};
    vecs[18] = '{0, SC_CMD_READ,  32'h30,  32'h0,         32'h1111_2222,  1, 0};
    vecs[19] = '{0, SC_CMD_READ,  32'h34,  32'h0,         32'h5555_5555,  1, 0};

    rst_n = 1'b0;
    req = '0; cmd = '0;
    for (int k = 0; k < 2; k++) begin
      addr[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset ack[%0d]", k), {31'b0, ack[k]}, 32'h0);
      check($sformatf("reset rdata[%0d]", k), rdata[k], 32'h0);
      check($sformatf("reset state[%0d]", k), {30'b0, st[k]}, {30'b0, ST_IDLE});
    end
    @(negedge clk);
    rst_n = 1'b1;

    // table-driven transactions
    for (int v = 0; v < NV; v++) begin
      txn(vecs[v].s, vecs[v].c, vecs[v].a, vecs[v].d, vecs[v].exp, vecs[v].chk,
          vecs[v].glitch, $sformatf("vec%0d", v));
    end

    // back-to-back: req held through ack, second write follows
    @(negedge clk);
    req[0] = 1'b1; cmd[0] = SC_CMD_WRITE; addr[0] = 32'h40; wdata[0] = 32'hA1A1_A1A1;
    found = 1'b0; t1 = 0; t2 = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (ack[0] === 1'b1) begin found = 1'b1; t1 = cyc; end
    end
    check("b2b first ack seen", {31'b0, found}, 32'd1);
    addr[0] = 32'h44; wdata[0] = 32'hB2B2_B2B2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk); #1;
      if (ack[0] === 1'b1) begin found = 1'b1; t2 = cyc; end
    end
    check("b2b second ack seen", {31'b0, found}, 32'd1);
    check("b2b ack spacing", t2 - t1, 32'd4);
    @(posedge clk); #1;
    req[0] = 1'b0;
    txn(0, SC_CMD_READ, 32'h40, 32'h0, 32'hA1A1_A1A1, 1, 0, "b2b rd first");
    txn(0, SC_CMD_READ, 32'h44, 32'h0, 32'hB2B2_B2B2, 1, 0, "b2b rd second");

    // reset while in WAIT drops the pending write
    txn(0, SC_CMD_WRITE, 32'h20, 32'hAAAA_5555, 32'h0, 0, 0, "rst pre-write");
    @(negedge clk);
    req[0] = 1'b1; cmd[0] = SC_CMD_WRITE; addr[0] = 32'h20; wdata[0] = 32'h1234_5678;
    @(posedge clk); #1;
    check("rst state before reset", {30'b0, st[0]}, {30'b0, ST_WAIT});
    #2;
    rst_n = 1'b0; req[0] = 1'b0;
    #1;
    check("rst state async", {30'b0, st[0]}, {30'b0, ST_IDLE});
    check("rst ack async", {31'b0, ack[0]}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("rst ack cycle%0d", i), {31'b0, ack[0]}, 32'h0);
      if (i == 1) begin
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    txn(0, SC_CMD_READ, 32'h20, 32'h0, 32'hAAAA_5555, 1, 0, "rst read old");

    // idle bus: no request for 20 cycles
    req[0] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check($sformatf("idle cyc%0d ack/state", i), {29'b0, ack[0], st[0]}, {29'b0, 1'b0, ST_IDLE});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
